// File: rtl/multicycle_control.sv
// Control FSM for the shared multi-cycle MIPS datapath: sequences fetch, decode and
// execute states, waits on the unified memory, and counts retired instructions.
module multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcwrite,
  output logic                 pcwritecond,
  output logic                 iord,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic                 regwrite,
  output logic                 link,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           immsel,
  output logic [1:0]           aluop,
  output logic [1:0]           pcsource,
  output logic [3:0]           state,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  state_t state_q;
  state_t state_d;
  logic   retire;

  // zero only feeds the datapath's PC-enable logic, never the controller outputs
  logic unused_zero;
  assign unused_zero = zero;

  assign state = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instr_count <= instr_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    link        = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    immsel      = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    illegal     = 1'b0;

    case (state_q)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = RTEXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J, OP_JAL: state_d = JUMP;
          OP_ORI, OP_LUI: state_d = IEXEC;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      RTEXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = RTWB;
      end
      RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        retire      = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        // PC already holds PC+4 here, so jal links it straight into $31
        if (opcode == OP_JAL) begin
          regwrite = 1'b1;
          link     = 1'b1;
        end
        retire  = 1'b1;
        state_d = FETCH;
      end
      IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        immsel  = (opcode == OP_LUI) ? 2'b10 : 2'b01;
        state_d = IWB;
      end
      IWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // A reset cycle must never leak a write or a request into the datapath
    if (reset) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      link        = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      immsel      = 2'b00;
      aluop       = 2'b00;
      pcsource    = 2'b00;
      illegal     = 1'b0;
      retire      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against an instruction-level model.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       link;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsel;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
    logic [3:0] state;
  } out_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] expState;
    logic [7:0] expStrobes;
    int         expCount;
  } vec_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic zero = 1'b0;
  logic memReady = 1'b0;

  logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst;
  logic regwrite, link, alusrca, illegal;
  logic [1:0] alusrcb, immsel, aluop, pcsource;
  logic [3:0] state;
  logic [31:0] instrCount;

  logic pcwrite2, pcwritecond2, iord2, memread2, memwrite2, irwrite2, memtoreg2, regdst2;
  logic regwrite2, link2, alusrca2, illegal2;
  logic [1:0] alusrcb2, immsel2, aluop2, pcsource2;
  logic [3:0] state2;
  logic [1:0] instrCount2;

  out_t obsNow, obs;
  logic [31:0] cnt;
  logic [1:0] cnt2;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multicycle_control #(.CNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(memReady),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .link(link), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsel(immsel), .aluop(aluop), .pcsource(pcsource), .state(state),
    .illegal(illegal), .instr_count(instrCount)
  );

  multicycle_control #(.CNT_WIDTH(2)) dutNarrow (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(memReady),
    .pcwrite(pcwrite2), .pcwritecond(pcwritecond2), .iord(iord2), .memread(memread2),
    .memwrite(memwrite2), .irwrite(irwrite2), .memtoreg(memtoreg2), .regdst(regdst2),
    .regwrite(regwrite2), .link(link2), .alusrca(alusrca2), .alusrcb(alusrcb2),
    .immsel(immsel2), .aluop(aluop2), .pcsource(pcsource2), .state(state2),
    .illegal(illegal2), .instr_count(instrCount2)
  );

  assign obsNow = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                   regdst, regwrite, link, alusrca, alusrcb, immsel, aluop, pcsource,
                   illegal, state};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, samples outputs at the falling edge, then crosses the rising edge
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic mr,
                               input logic z);
    reset = r;
    opcode = op;
    memReady = mr;
    zero = z;
    @(negedge clock);
    obs = obsNow;
    cnt = instrCount;
    cnt2 = instrCount2;
    @(posedge clock);
    #1;
  endtask

  function automatic logic isLegal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ORI, OP_LUI};
  endfunction

  // Expected outputs for a given state number, straight from the per-state output lists
  function automatic out_t expOut(input int st, input logic [5:0] op, input logic mr);
    out_t e;
    e = '0;
    e.state = 4'(st);
    case (st)
      0: begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr; end
      1: begin e.alusrcb = 2'b11; e.illegal = !isLegal(op); end
      2: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3: begin e.memread = 1; e.iord = 1; end
      4: begin e.regwrite = 1; e.memtoreg = 1; end
      5: begin e.memwrite = 1; e.iord = 1; end
      6: begin e.alusrca = 1; e.aluop = 2'b10; end
      7: begin e.regwrite = 1; e.regdst = 1; end
      8: begin e.alusrca = 1; e.aluop = 2'b01; e.pcwritecond = 1; e.pcsource = 2'b01; end
      9: begin e.pcwrite = 1; e.pcsource = 2'b10; e.regwrite = (op == OP_JAL); e.link = (op == OP_JAL); end
      10: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b11; e.immsel = (op == OP_LUI) ? 2'b10 : 2'b01; end
      11: e.regwrite = 1;
      default: ;
    endcase
    return e;
  endfunction

  vec_t vecs[21];
  int plan[$];
  int expCount;
  int irPulses, pcwPulses;
  logic mrPat[10];
  int lwStates[10];
  logic [5:0] curOp;
  logic r, mr, z;
  out_t e;

  initial begin
    // reset, lw abandoned mid-MEMRD by reset, R-type, beq, illegal, R-type with fetch wait
    vecs[0]  = '{1'b0, OP_LW,  1'b1, 4'd0, 8'b10010100, 0};
    vecs[1]  = '{1'b0, OP_LW,  1'b1, 4'd1, 8'b00000000, 0};
    vecs[2]  = '{1'b0, OP_LW,  1'b1, 4'd2, 8'b00000000, 0};
    vecs[3]  = '{1'b0, OP_LW,  1'b0, 4'd3, 8'b00110000, 0};
    vecs[4]  = '{1'b1, OP_LW,  1'b0, 4'd3, 8'b00000000, 0};
    vecs[5]  = '{1'b1, OP_LW,  1'b0, 4'd0, 8'b00000000, 0};
    vecs[6]  = '{1'b0, OP_R,   1'b1, 4'd0, 8'b10010100, 0};
    vecs[7]  = '{1'b0, OP_R,   1'b1, 4'd1, 8'b00000000, 0};
    vecs[8]  = '{1'b0, OP_R,   1'b1, 4'd6, 8'b00000000, 0};
    vecs[9]  = '{1'b0, OP_R,   1'b1, 4'd7, 8'b00000010, 0};
    vecs[10] = '{1'b0, OP_BEQ, 1'b1, 4'd0, 8'b10010100, 1};
    vecs[11] = '{1'b0, OP_BEQ, 1'b1, 4'd1, 8'b00000000, 1};
    vecs[12] = '{1'b0, OP_BEQ, 1'b1, 4'd8, 8'b01000000, 1};
    vecs[13] = '{1'b0, OP_BAD, 1'b1, 4'd0, 8'b10010100, 2};
    vecs[14] = '{1'b0, OP_BAD, 1'b1, 4'd1, 8'b00000001, 2};
    vecs[15] = '{1'b0, OP_R,   1'b0, 4'd0, 8'b00010000, 2};
    vecs[16] = '{1'b0, OP_R,   1'b1, 4'd0, 8'b10010100, 2};
    vecs[17] = '{1'b0, OP_R,   1'b1, 4'd1, 8'b00000000, 2};
    vecs[18] = '{1'b0, OP_R,   1'b1, 4'd6, 8'b00000000, 2};
    vecs[19] = '{1'b0, OP_R,   1'b1, 4'd7, 8'b00000010, 2};
    vecs[20] = '{1'b0, OP_R,   1'b0, 4'd0, 8'b00010000, 3};

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].mr, 1'b0);
      checkOutput($sformatf("vec%0d state", i), 32'(obs.state), 32'(vecs[i].expState));
      checkOutput($sformatf("vec%0d strobes", i),
                  32'({obs.pcwrite, obs.pcwritecond, obs.iord, obs.memread, obs.memwrite,
                       obs.irwrite, obs.regwrite, obs.illegal}),
                  32'(vecs[i].expStrobes));
      checkOutput($sformatf("vec%0d count", i), cnt, 32'(vecs[i].expCount));
    end
    expCount = 3;

    // lw with 3 fetch waits and 2 MEMRD waits: exactly 10 cycles
    mrPat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    lwStates = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4};
    irPulses = 0;
    pcwPulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, OP_LW, mrPat[i], 1'b0);
      checkOutput($sformatf("lw cyc%0d state", i), 32'(obs.state), 32'(lwStates[i]));
      irPulses += int'(obs.irwrite);
      pcwPulses += int'(obs.pcwrite);
      if (lwStates[i] == 0)
        checkOutput($sformatf("lw cyc%0d fetch req", i), 32'({obs.memread, obs.iord}), 32'(2'b10));
      if (lwStates[i] == 3)
        checkOutput($sformatf("lw cyc%0d memrd req", i), 32'({obs.memread, obs.iord}), 32'(2'b11));
      if (lwStates[i] == 4)
        checkOutput("lw memtoreg", 32'({obs.memtoreg, obs.regwrite}), 32'(2'b11));
    end
    checkOutput("lw irwrite pulses", 32'(irPulses), 32'd1);
    checkOutput("lw pcwrite pulses", 32'(pcwPulses), 32'd1);
    expCount++;

    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, OP_BEQ, 1'b1, k == 0);
      checkOutput("beq fetch state", 32'(obs.state), 32'd0);
      checkOutput("beq fetch count", cnt, 32'(expCount));
      applyStimulus(1'b0, OP_BEQ, 1'b1, k == 0);
      applyStimulus(1'b0, OP_BEQ, 1'b1, k == 0);
      checkOutput($sformatf("beq%0d state", k), 32'(obs.state), 32'd8);
      checkOutput($sformatf("beq%0d pcwritecond/pcsource/pcwrite", k),
                  32'({obs.pcwritecond, obs.pcsource, obs.pcwrite}), 32'(4'b1010));
      expCount++;
    end

    for (int k = 0; k < 2; k++) begin
      curOp = (k == 0) ? OP_JAL : OP_J;
      applyStimulus(1'b0, curOp, 1'b1, 1'b0);
      applyStimulus(1'b0, curOp, 1'b1, 1'b0);
      applyStimulus(1'b0, curOp, 1'b1, 1'b0);
      checkOutput($sformatf("jump%0d state", k), 32'(obs.state), 32'd9);
      checkOutput($sformatf("jump%0d pcwrite/pcsource", k),
                  32'({obs.pcwrite, obs.pcsource}), 32'(3'b110));
      checkOutput($sformatf("jump%0d regwrite/link", k),
                  32'({obs.regwrite, obs.link}), (k == 0) ? 32'(2'b11) : 32'(2'b00));
      expCount++;
    end

    applyStimulus(1'b0, OP_R, 1'b0, 1'b0);
    checkOutput("count after directed", cnt, 32'(expCount));
    checkOutput("narrow count wrap", 32'(cnt2), 32'(expCount % 4));

    // Randomized traffic against an instruction-level model
    applyStimulus(1'b1, OP_R, 1'b0, 1'b0);
    expCount = 0;
    plan.delete();
    curOp = OP_R;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (plan.size() == 0) begin
        if ($urandom_range(0, 99) < 80) begin
          case ($urandom_range(0, 7))
            0: curOp = OP_R;
            1: curOp = OP_LW;
            2: curOp = OP_SW;
            3: curOp = OP_BEQ;
            4: curOp = OP_J;
            5: curOp = OP_JAL;
            6: curOp = OP_ORI;
            default: curOp = OP_LUI;
          endcase
        end else begin
          curOp = 6'($urandom_range(0, 63));
        end
        case (curOp)
          OP_R:         plan = '{0, 1, 6, 7};
          OP_LW:        plan = '{0, 1, 2, 3, 4};
          OP_SW:        plan = '{0, 1, 2, 5};
          OP_BEQ:       plan = '{0, 1, 8};
          OP_J, OP_JAL: plan = '{0, 1, 9};
          OP_ORI, OP_LUI: plan = '{0, 1, 10, 11};
          default:      plan = '{0, 1};
        endcase
      end
      r = ($urandom_range(0, 99) == 0);
      mr = ($urandom_range(0, 99) < 70);
      z = 1'($urandom_range(0, 1));
      if (r) begin
        e = '0;
        e.state = 4'(plan[0]);
      end else begin
        e = expOut(plan[0], curOp, mr);
      end
      applyStimulus(r, curOp, mr, z);
      checkOutput($sformatf("rand%0d outputs", cyc), 32'(obs), 32'(e));
      checkOutput($sformatf("rand%0d count", cyc), cnt, 32'(expCount));
      checkOutput($sformatf("rand%0d narrow count", cyc), 32'(cnt2), 32'(expCount % 4));
      if (r) begin
        plan.delete();
        expCount = 0;
      end else if (mr || !(plan[0] inside {0, 3, 5})) begin
        void'(plan.pop_front());
        if (plan.size() == 0 && isLegal(curOp)) expCount++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
